// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU.
//
// The block drives the enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers, and the PC write enable. It handles four situations:
//   - load-use hazards, with a one-cycle bubble;
//   - taken branches, which flush the two younger stages;
//   - multi-cycle data-memory waits, which freeze the pipe;
//   - a sticky timeout error state, left only through RSTn.
// All outputs are combinational from the current state and the inputs, so they
// take effect in the same cycle.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the saturating
// stall_cycles and flush_events counters. Without it, both ports are tied to 0.

module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_MemRead,
    input  logic [REG_ADDR_W-1:0] ex_WriteReg,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int unsigned TcntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TcntW-1:0] TcntLast = TcntW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun,
        StLdStall,
        StMemWait,
        StError
    } state_e;

    state_e           state_q, state_d;
    logic [TcntW-1:0] tcnt_q, tcnt_d;
    logic             hazard;
    logic             mem_miss;

    // Load-use hazard: a load in EX writes a register that the ID instruction reads.
    // Register 0 is never a real dependency.
    always_comb begin
        hazard = ex_MemRead && (ex_WriteReg != '0) &&
                 ((ex_WriteReg == id_rs) || (id_uses_rt && (ex_WriteReg == id_rt)));
        mem_miss = mem_req && !mem_ready;
    end

    // Next state, timeout counter and the pipeline control outputs.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mem_timeout = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_miss) begin
                    {pc_en, if_id_en, ex_mem_en, mem_wb_en} = 4'b0000;
                    state_d = StMemWait;
                    tcnt_d  = TcntW'(1);
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hazard) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    state_d     = StLdStall;
                end
            end
            // The bubble is in EX now, so hazard detection is masked for this cycle.
            StLdStall: begin
                if (mem_miss) begin
                    {pc_en, if_id_en, ex_mem_en, mem_wb_en} = 4'b0000;
                    state_d = StMemWait;
                    tcnt_d  = TcntW'(1);
                end else begin
                    state_d = StRun;
                end
            end
            // If mem_req drops, the access is abandoned and treated like completion.
            StMemWait: begin
                if (mem_ready || !mem_req) begin
                    state_d = StRun;
                    tcnt_d  = '0;
                end else begin
                    {pc_en, if_id_en, ex_mem_en, mem_wb_en} = 4'b0000;
                    if (tcnt_q == TcntLast) begin
                        state_d = StError;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TcntW'(1);
                    end
                end
            end
            StError: begin
                {pc_en, if_id_en, ex_mem_en, mem_wb_en} = 4'b0000;
                mem_timeout = 1'b1;
            end
            default: begin
                state_d = StRun;
                tcnt_d  = '0;
            end
        endcase

        // While reset is held, the pipe is quiescent and no error is reported.
        if (!RSTn) begin
            {pc_en, if_id_en, ex_mem_en, mem_wb_en} = 4'b0000;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    // State register; reset returns to RUN and discards any wait in progress.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StRun;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             branch_flush;

    // A branch flush is counted only when it actually happens in RUN.
    always_comb begin
        branch_flush = (state_q == StRun) && !mem_miss && ex_branch_taken;
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (branch_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
